sipo_rx: RTL and testbench
==========================

// Module: sipo_rx
// PURPOSE
//  Serial-to-parallel frame receiver; consumes the serial stream a piso stage emits.
//  Hunts a start bit, shifts WIDTH data bits MSB-first, checks the stop bit, then presents the word.
//  Output side is a one-word holding register with a valid/ready handshake.
//  Sits between the serial link and the parallel datapath, one per serial lane.
// PARAMETERS
//  WIDTH    4   data bits per frame (>=2); matches upstream piso word width
//  CNT_W    $clog2(WIDTH)   bit-counter width (derived, not overridden)
// PORTS
//  clk         in   1      single clock; all state changes on posedge clk
//  rst         in   1      synchronous reset, active-high
//  si          in   1      serial data in; line idles high
//  bit_en      in   1      bit strobe: si is sampled only on cycles where bit_en=1
//  dout        out  WIDTH  received word (first-received bit in dout[WIDTH-1])
//  dout_valid  out  1      dout holds an unconsumed word
//  dout_ready  in   1      consumer accepts dout this cycle when dout_valid=1
//  frame_err   out  1      1-cycle pulse: stop bit sampled as 0
//  overrun     out  1      1-cycle pulse: good frame dropped, holding register full
//  parity_err  out  1      1-cycle pulse: parity mismatch (tied 0 without parity build)
// BEHAVIOUR
//  Reset: state=IDLE, bit count=0, shift reg=0, dout=0, dout_valid=0, all pulses 0.
//  Reset mid-frame discards the partial frame; the next frame needs a new start bit.
//  All FSM moves and shifts happen only when bit_en=1; with bit_en=0 the FSM holds.
//  FSM: IDLE -> DATA on sampled si=0 (start bit); si=1 stays in IDLE.
//   DATA: sr <= {sr[WIDTH-2:0], si}, cnt++; after the WIDTH-th bit -> PARITY (if built) else STOP.
//   PARITY: compare si with the even parity of sr; remember the mismatch; -> STOP.
//   STOP: si=1 and no parity mismatch -> commit; si=0 -> frame_err, drop.
//         Parity mismatch with si=1 -> parity_err, drop. Always -> IDLE; no back-to-back start.
//  Commit: dout<=sr and dout_valid<=1 on the stop-sample edge. Latency: valid is visible on the
//   cycle after the edge that sampled the stop bit.
//  Handshake: dout_valid&dout_ready at an edge clears dout_valid. dout stays stable while valid=1.
//  Commit with valid=1 and ready=0: frame dropped, overrun pulses, dout/valid unchanged.
//  Commit on the same cycle valid&ready=1: the new word loads, valid stays 1, no overrun.
//  Error precedence at STOP: frame_err > parity_err > overrun. Only one pulse per frame.
// CONFIGURATION
//  SIPO_RX_PARITY_EN defined: one even-parity bit follows the data bits (frame = 1+WIDTH+1+1).
//  Undefined: no PARITY state, frame = 1+WIDTH+1 bits, parity_err tied 0. The port list is unchanged.
// STRUCTURE
//  Shared package serial_pkg: state enum (IDLE, DATA, PARITY, STOP) as localparams,
//   line-idle constant (1'b1), start/stop bit constants. Upstream piso reuses these constants.
//  One natural sub-module: sipo_rx_hold (holding register + valid/ready + overrun detect).
//  Bit counter, shift register and FSM stay in the top module.
// TESTING (WIDTH=4, bit_en=1 every cycle unless stated)
//  Frame 0,1,0,1,1,1 with ready=0 -> dout=4'hB, dout_valid=1 after the stop edge; holds until ready=1.
//  Frame with stop bit 0 (0,1,1,1,1,0) -> frame_err 1-cycle pulse, dout_valid stays 0, FSM back in IDLE.
//  Two good frames 4'hB then 4'h3 with ready=0 -> overrun pulses on 2nd commit, dout stays 4'hB.
//  ready=1 held on the commit cycle of the 2nd frame -> dout=4'h3, valid continuous, no overrun.
//  bit_en=1 every 3rd cycle, frame 4'h6 -> same result as the dense case, no extra shifts.
//  rst=1 after 2 data bits, then full frame 4'h9 -> dout=4'h9, no err pulses; with PARITY_EN,
//   frame 4'h9 with parity bit 1 -> parity_err pulse, nothing committed.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared serial-link constants: FSM state codes and line-level bit values.
// Used by sipo_rx (build option SIPO_RX_PARITY_EN) and the upstream piso.
package serial_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_DATA   = 2'd1;
    localparam state_t ST_PARITY = 2'd2;
    localparam state_t ST_STOP   = 2'd3;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/sipo_rx_hold.sv
// One-word output holding register with valid/ready handshake.
// A commit into a full, unconsumed register is dropped and flagged as overrun.
module sipo_rx_hold #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_commit,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic             o_overrun
);

    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic             r_overrun;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (i_commit) begin
                // A word leaving this very cycle frees the slot for the new one.
                if (r_valid && !i_ready) begin
                    r_overrun <= 1'b1;
                end else begin
                    r_data  <= i_data;
                    r_valid <= 1'b1;
                end
            end else if (r_valid && i_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_data    = r_data;
    assign o_valid   = r_valid;
    assign o_overrun = r_overrun;

endmodule

// File: rtl/sipo_rx.sv
// Serial frame receiver: start bit, WIDTH data bits MSB-first, optional parity, stop bit.
// Define SIPO_RX_PARITY_EN to expect an even-parity bit after the data bits.
module sipo_rx
    import serial_pkg::*;
#(
    parameter int WIDTH = 4,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             si,
    input  logic             bit_en,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             frame_err,
    output logic             overrun,
    output logic             parity_err
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_sr;
    logic             r_frame_err;
    logic             r_parity_err;
    logic             w_shift;
    logic             w_par_smp;
    logic             w_stop_smp;
    logic             w_commit;
    logic             w_par_bad;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else if (bit_en) begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (si == START_BIT) w_next = ST_DATA;
            end
            ST_DATA: begin
`ifdef SIPO_RX_PARITY_EN
                if (r_cnt == LAST) w_next = ST_PARITY;
`else
                if (r_cnt == LAST) w_next = ST_STOP;
`endif
            end
            ST_PARITY: w_next = ST_STOP;
            ST_STOP:   w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_shift    = bit_en && (r_state == ST_DATA);
        w_par_smp  = bit_en && (r_state == ST_PARITY);
        w_stop_smp = bit_en && (r_state == ST_STOP);
        w_commit   = w_stop_smp && (si == STOP_BIT) && !w_par_bad;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_sr  <= '0;
        end else if (w_shift) begin
            r_sr  <= {r_sr[WIDTH-2:0], si};
            r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
        end
    end

`ifdef SIPO_RX_PARITY_EN
    logic r_par_bad;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_par_bad <= 1'b0;
        end else if (w_par_smp) begin
            r_par_bad <= (si != ^r_sr);
        end
    end

    assign w_par_bad = r_par_bad;
`else
    assign w_par_bad = 1'b0;
`endif

    // Stop-bit errors outrank parity; overrun only arises from a clean commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            r_frame_err  <= w_stop_smp && (si != STOP_BIT);
            r_parity_err <= w_stop_smp && (si == STOP_BIT) && w_par_bad;
        end
    end

    sipo_rx_hold #(
        .WIDTH(WIDTH)
    ) u_hold (
        .clk      (clk),
        .rst      (rst),
        .i_commit (w_commit),
        .i_data   (r_sr),
        .i_ready  (dout_ready),
        .o_data   (dout),
        .o_valid  (dout_valid),
        .o_overrun(overrun)
    );

    assign frame_err  = r_frame_err;
    assign parity_err = r_parity_err;

endmodule

// File: tb/tb_sipo_rx.sv
// Directed plus randomized frame stimulus against a frame-level receiver model.
// Builds with or without SIPO_RX_PARITY_EN.
module tb_sipo_rx;
    import serial_pkg::*;

    localparam int W = 4;

    typedef enum int {EV_NONE, EV_OK, EV_FERR, EV_PERR} ev_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         si;
    logic         bit_en;
    logic         dout_ready;
    logic [W-1:0] dout;
    logic         dout_valid;
    logic         frame_err;
    logic         overrun;
    logic         parity_err;

    int checks = 0;
    int errors = 0;
    int rdy_mode = 0;

    logic [W-1:0] m_dout;
    logic         m_valid;

    always #5 clk = ~clk;

    sipo_rx #(
        .WIDTH(W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .si        (si),
        .bit_en    (bit_en),
        .dout      (dout),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .parity_err(parity_err)
    );

    task automatic chk(input string tag, input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input logic eo, input logic ef, input logic ep);
        chk("dout_valid", W'(dout_valid), W'(m_valid));
        chk("dout", dout, m_dout);
        chk("frame_err", W'(frame_err), W'(ef));
        chk("overrun", W'(overrun), W'(eo));
        chk("parity_err", W'(parity_err), W'(ep));
    endtask

    // One clock: ev tells the model what the frame outcome is on this edge.
    task automatic tick(input logic s, input logic e, input ev_t ev,
                        input logic [W-1:0] d);
        logic r;
        logic eo;
        case (rdy_mode)
            0:       r = 1'b0;
            1:       r = 1'b1;
            2:       r = 1'($urandom_range(0, 1));
            default: r = (ev != EV_NONE);
        endcase
        si = s;
        bit_en = e;
        dout_ready = r;
        eo = 1'b0;
        if (ev == EV_OK) begin
            if (m_valid && !r) begin
                eo = 1'b1;
            end else begin
                m_dout = d;
                m_valid = 1'b1;
            end
        end else if (m_valid && r) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        check_all(eo, ev == EV_FERR, ev == EV_PERR);
    endtask

    task automatic send_bit(input logic b, input int gap, input ev_t ev,
                            input logic [W-1:0] d);
        for (int i = 1; i < gap; i++)
            tick(1'($urandom_range(0, 1)), 1'b0, EV_NONE, '0);
        tick(b, 1'b1, ev, d);
    endtask

    task automatic frame(input logic [W-1:0] d, input logic stop,
                         input logic pflip, input int gap);
        ev_t  ev;
        logic pe;
        pe = pflip;
`ifndef SIPO_RX_PARITY_EN
        pe = 1'b0;
`endif
        ev = !stop ? EV_FERR : (pe ? EV_PERR : EV_OK);
        send_bit(START_BIT, gap, EV_NONE, '0);
        for (int i = W - 1; i >= 0; i--)
            send_bit(d[i], gap, EV_NONE, '0);
`ifdef SIPO_RX_PARITY_EN
        send_bit((^d) ^ pflip, gap, EV_NONE, '0);
`endif
        send_bit(stop, gap, ev, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            tick(LINE_IDLE, 1'b1, EV_NONE, '0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        si = LINE_IDLE;
        bit_en = 1'b1;
        dout_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_valid = 1'b0;
        m_dout = '0;
        check_all(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        si = LINE_IDLE;
        bit_en = 1'b0;
        dout_ready = 1'b0;
        m_valid = 1'b0;
        m_dout = '0;
        do_reset();

        rdy_mode = 0;
        frame(4'hB, 1'b1, 1'b0, 1);
        idle(3);
        rdy_mode = 1;
        idle(1);

        rdy_mode = 0;
        frame(4'hF, 1'b0, 1'b0, 1);
        frame(4'hB, 1'b1, 1'b0, 1);
        frame(4'h3, 1'b1, 1'b0, 1);
        rdy_mode = 3;
        frame(4'h3, 1'b1, 1'b0, 1);
        rdy_mode = 1;
        idle(2);

        rdy_mode = 0;
        frame(4'h6, 1'b1, 1'b0, 3);
        idle(2);

        send_bit(START_BIT, 1, EV_NONE, '0);
        send_bit(1'b1, 1, EV_NONE, '0);
        send_bit(1'b0, 1, EV_NONE, '0);
        do_reset();
        frame(4'h9, 1'b1, 1'b0, 1);
        rdy_mode = 1;
        idle(1);
        rdy_mode = 0;
`ifdef SIPO_RX_PARITY_EN
        frame(4'h9, 1'b1, 1'b1, 1);
        idle(1);
`endif

        rdy_mode = 2;
        repeat (150) begin
            frame(W'($urandom), ($urandom_range(0, 9) != 0),
                  ($urandom_range(0, 7) == 0), int'($urandom_range(1, 3)));
            idle(int'($urandom_range(0, 2)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
